// File: rtl/act_nz_reader.sv
// Sparse activation scanner: reads only the nonzero entries of a PE activation register file
// and streams {addr, data} pairs downstream over valid/ready, lowest address first.
module act_nz_reader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ACT_NO     = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic                  clear_i,
    input  logic [ACT_NO-1:0]     zeros_i,
    output logic                  act_read_en_o,
    output logic [ADDR_WIDTH-1:0] act_read_addr_o,
    input  logic [DATA_WIDTH-1:0] act_read_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ADDR_WIDTH-1:0] out_addr_o,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [ADDR_WIDTH:0]   nnz_o,
    output logic                  busy_o,
    output logic                  done_o
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e                state_q, state_d;
    logic [ACT_NO-1:0]     mask_q, mask_d;
    logic [ADDR_WIDTH:0]   nnz_q, nnz_d;
    logic                  inflight_q, inflight_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;

    logic [ADDR_WIDTH-1:0] buf_addr_q [2];
    logic [DATA_WIDTH-1:0] buf_data_q [2];
    logic                  rd_ptr_q, wr_ptr_q;
    logic [1:0]            count_q;

    logic [ADDR_WIDTH-1:0] cand;
    logic [ADDR_WIDTH:0]   popcnt;
    logic                  fifo_nz;
    logic                  xfer;
    logic [2:0]            occ;
    logic                  issue;
    logic                  push;
    logic                  pop;

    // Lowest set bit of the pending mask.
    always_comb begin
        cand = '0;
        for (int i = int'(ACT_NO) - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                cand = ADDR_WIDTH'(i);
            end
        end
    end

    always_comb begin
        popcnt = '0;
        for (int i = 0; i < int'(ACT_NO); i++) begin
            popcnt = popcnt + (ADDR_WIDTH + 1)'(~zeros_i[i]);
        end
    end

    // The in-flight read acts as the tail entry of the queue; its data is forwarded live
    // from the register file on the cycle it returns, then parked in the FIFO if not taken.
    always_comb begin
        fifo_nz     = (count_q != 2'd0);
        out_valid_o = fifo_nz | inflight_q;
        xfer        = out_valid_o & out_ready_i;
        occ         = 3'(count_q) + 3'(inflight_q) - 3'(xfer);
        issue       = (state_q == StScan) && (mask_q != '0) && (occ < 3'd2) && !clear_i;
        push        = inflight_q & ~(~fifo_nz & xfer);
        pop         = xfer & fifo_nz;

        act_read_en_o   = issue;
        act_read_addr_o = issue ? cand : rd_addr_q;

        if (fifo_nz) begin
            out_addr_o = buf_addr_q[rd_ptr_q];
            out_data_o = buf_data_q[rd_ptr_q];
        end else if (inflight_q) begin
            out_addr_o = rd_addr_q;
            out_data_o = act_read_data_i;
        end else begin
            out_addr_o = '0;
            out_data_o = '0;
        end

        busy_o = (state_q != StIdle);
        done_o = (state_q == StDone);
        nnz_o  = nnz_q;
    end

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        nnz_d      = nnz_q;
        inflight_d = issue;
        rd_addr_d  = act_read_addr_o;

        if (issue) begin
            mask_d = mask_q & (mask_q - ACT_NO'(1));
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    mask_d  = ~zeros_i;
                    nnz_d   = popcnt;
                    state_d = (~zeros_i != '0) ? StScan : StDone;
                end
            end
            StScan: begin
                // Leave on the cycle the final entry is handed off.
                if ((mask_q == '0) && (occ == 3'd0)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (clear_i) begin
            state_d    = StIdle;
            mask_d     = '0;
            inflight_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            mask_q     <= '0;
            nnz_q      <= '0;
            inflight_q <= 1'b0;
            rd_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            nnz_q      <= nnz_d;
            inflight_q <= inflight_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 2; i++) begin
                buf_addr_q[i] <= '0;
                buf_data_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (clear_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                buf_addr_q[wr_ptr_q] <= rd_addr_q;
                buf_data_q[wr_ptr_q] <= act_read_data_i;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule
